// File: rtl/canonical_huffman_decoder.sv
// Canonical Huffman decoder: loads a per-symbol code-length table, rebuilds the
// canonical symbol order, then decodes an MSB-first bitstream one bit per cycle.
module canonical_huffman_decoder #(
    parameter int SYMBOL_WIDTH = 5,
    parameter int NUM_SYMBOLS  = 16,
    parameter int MAX_CODE_LEN = 15,
    parameter int LEN_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    table_clear,
    input  logic [LEN_WIDTH-1:0]    len_in,
    input  logic                    len_valid,
    output logic                    len_ready,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic [SYMBOL_WIDTH-1:0] symbol_out,
    output logic                    symbol_valid,
    input  logic                    symbol_ready,
    output logic                    table_ready,
    output logic                    error
);

    localparam int IDX_W  = $clog2(NUM_SYMBOLS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int CODE_W = MAX_CODE_LEN + 1;
    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(MAX_CODE_LEN);

    typedef enum logic [1:0] {LOAD, BUILD, DECODE} state_t;

    state_t                  state, state_next;
    logic [LEN_WIDTH-1:0]    len_tbl  [NUM_SYMBOLS];
    logic [CNT_W-1:0]        bl_count [MAX_CODE_LEN+1];
    logic [SYMBOL_WIDTH-1:0] sorted   [NUM_SYMBOLS];
    logic [IDX_W-1:0]        load_idx, build_sym, wr_ptr;
    logic [LEN_WIDTH-1:0]    build_len, depth;
    logic [CODE_W-1:0]       code, first;
    logic [SYMBOL_WIDTH-1:0] index;

    logic                    len_accept, bit_accept, load_last, build_last;
    logic [LEN_WIDTH-1:0]    len_store, depth_next;
    logic [CODE_W-1:0]       code_bit, offset;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        pos;
    logic                    hit, give_up;

    assign len_ready   = (state == LOAD);
    assign table_ready = (state == DECODE);
    assign bit_ready   = (state == DECODE) && !symbol_valid && !error;
    assign len_accept  = len_valid && len_ready;
    assign bit_accept  = bit_valid && bit_ready;

    assign load_last  = (load_idx == IDX_W'(NUM_SYMBOLS-1));
    assign build_last = (build_len == LEN_WIDTH'(MAX_CODE_LEN-1)) &&
                        (build_sym == IDX_W'(NUM_SYMBOLS-1));
    assign len_store  = ({1'b0, len_in} <= MAX_LEN) ? len_in : '0;

    // One canonical-tree step: is the partial code inside the block of codes of this length?
    assign depth_next = depth + 1'b1;
    assign code_bit   = code | CODE_W'(bit_in);
    assign cnt        = bl_count[depth_next];
    assign offset     = code_bit - first;
    assign hit        = offset < CODE_W'(cnt);
    assign pos        = IDX_W'(index) + IDX_W'(offset);
    assign give_up    = (depth_next == LEN_WIDTH'(MAX_CODE_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (table_clear) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (len_accept && load_last) state_next = BUILD;
                BUILD:   if (build_last) state_next = DECODE;
                DECODE:  state_next = DECODE;
                default: state_next = LOAD;
            endcase
        end
    end

    // NOTE: the tables are small register arrays, so they are cleared on reset and
    // table_clear; a stale bl_count entry would corrupt the next table's decode.
    task automatic clear_regs();
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            len_tbl[i] <= '0;
            sorted[i]  <= '0;
        end
        for (int i = 0; i <= MAX_CODE_LEN; i++) bl_count[i] <= '0;
        load_idx     <= '0;
        build_sym    <= '0;
        build_len    <= '0;
        wr_ptr       <= '0;
        code         <= '0;
        first        <= '0;
        index        <= '0;
        depth        <= '0;
        symbol_out   <= '0;
        symbol_valid <= 1'b0;
        error        <= 1'b0;
    endtask

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_regs();
        end else if (table_clear) begin
            clear_regs();
        end else begin
            case (state)
                LOAD: if (len_accept) begin
                    len_tbl[load_idx] <= len_store;
                    if (len_store != '0) bl_count[len_store] <= bl_count[len_store] + 1'b1;
                    load_idx <= load_last ? '0 : load_idx + 1'b1;
                end
                BUILD: begin
                    // build_len holds L-1 so the scan counters start from zero
                    if (len_tbl[build_sym] == build_len + 1'b1) begin
                        sorted[wr_ptr] <= SYMBOL_WIDTH'(build_sym);
                        wr_ptr         <= wr_ptr + 1'b1;
                    end
                    if (build_sym == IDX_W'(NUM_SYMBOLS-1)) begin
                        build_sym <= '0;
                        build_len <= build_len + 1'b1;
                    end else begin
                        build_sym <= build_sym + 1'b1;
                    end
                end
                DECODE: begin
                    if (symbol_valid && symbol_ready) symbol_valid <= 1'b0;
                    if (bit_accept) begin
                        if (hit) begin
                            symbol_out   <= sorted[pos];
                            symbol_valid <= 1'b1;
                            code  <= '0;
                            first <= '0;
                            index <= '0;
                            depth <= '0;
                        end else if (give_up) begin
                            error <= 1'b1;
                            code  <= '0;
                            first <= '0;
                            index <= '0;
                            depth <= '0;
                        end else begin
                            index <= index + SYMBOL_WIDTH'(cnt);
                            first <= (first + CODE_W'(cnt)) << 1;
                            code  <= code_bit << 1;
                            depth <= depth_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Scoreboard bench for canonical_huffman_decoder: an encoder-side model assigns
// canonical codes, the driver streams bits, and a monitor checks emitted symbols.
module tb_canonical_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset, table_clear, len_valid, bit_in, bit_valid, symbol_ready;
    logic [3:0] len_in;
    logic       len_ready, bit_ready, symbol_valid, table_ready, error;
    logic [4:0] symbol_out;

    canonical_huffman_decoder dut (
        .clk(clk), .reset(reset), .table_clear(table_clear),
        .len_in(len_in), .len_valid(len_valid), .len_ready(len_ready),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .symbol_out(symbol_out), .symbol_valid(symbol_valid), .symbol_ready(symbol_ready),
        .table_ready(table_ready), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tbl[16];
    int code_of[16];
    int len_of[16];
    int exp_q[$];
    bit bit_q[$];
    bit ready_hold = 1'b0;
    bit ready_random = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer side: symbol_ready is updated mid-cycle, away from the clock edge.
    initial begin
        symbol_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            symbol_ready = ready_hold ? 1'b0 : (ready_random ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: every handshake pops exactly one expected symbol.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && symbol_valid && symbol_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_symbol: got %0d, expected none (t=%0t)", symbol_out, $time);
                end else begin
                    check("symbol", symbol_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Canonical assignment as an encoder would do it: sort by (length, symbol),
    // then next code = (previous + 1) shifted by the length step.
    function automatic void build_model();
        int keys[$];
        int code = 0;
        int prev = 0;
        int l, s;
        for (int k = 0; k < 16; k++) begin
            len_of[k]  = tbl[k];
            code_of[k] = 0;
            if (tbl[k] != 0) keys.push_back(tbl[k] * 16 + k);
        end
        keys.sort();
        for (int i = 0; i < keys.size(); i++) begin
            l = keys[i] / 16;
            s = keys[i] % 16;
            if (i > 0) code = (code + 1) << (l - prev);
            code_of[s] = code;
            prev = l;
        end
    endfunction

    // Random prefix-free length set: split random leaves of a binary tree,
    // optionally drop one leaf, then scatter the lengths over shuffled symbols.
    function automatic void rand_table();
        int leaves[$];
        int perm[16];
        int n, i, d, j, t;
        leaves.push_back(1);
        leaves.push_back(1);
        n = $urandom_range(2, 16);
        while (leaves.size() < n) begin
            i = $urandom_range(0, leaves.size() - 1);
            d = leaves[i];
            leaves.delete(i);
            leaves.push_back(d + 1);
            leaves.push_back(d + 1);
        end
        if (leaves.size() > 2 && $urandom_range(0, 1) == 1)
            leaves.delete($urandom_range(0, leaves.size() - 1));
        for (int k = 0; k < 16; k++) perm[k] = k;
        for (int k = 15; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = perm[k];
            perm[k] = perm[j];
            perm[j] = t;
        end
        for (int k = 0; k < 16; k++) tbl[k] = 0;
        for (int k = 0; k < leaves.size(); k++) tbl[perm[k]] = leaves[k];
    endfunction

    task automatic push_symbol(input int s);
        exp_q.push_back(s);
        for (int b = len_of[s] - 1; b >= 0; b--) bit_q.push_back(1'((code_of[s] >> b) & 1));
    endtask

    task automatic queue_bits(input string s);
        for (int i = 0; i < s.len(); i++) bit_q.push_back(s[i] == 8'h31);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_defaults(input string tag);
        check({tag, " len_ready"}, len_ready, 1);
        check({tag, " bit_ready"}, bit_ready, 0);
        check({tag, " symbol_valid"}, symbol_valid, 0);
        check({tag, " symbol_out"}, symbol_out, 0);
        check({tag, " table_ready"}, table_ready, 0);
        check({tag, " error"}, error, 0);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic load_table(input int mode);
        table_clear = 1'b1;
        cycle();
        table_clear = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                len_valid = 1'b0;
                cycle();
            end
            len_in    = 4'(tbl[k]);
            len_valid = 1'b1;
            cycle();
        end
        len_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!table_ready && c < 400) begin
            cycle();
            c++;
        end
        check("table_ready within budget", table_ready, 1);
    endtask

    task automatic send_bits(input int mode);
        int waited;
        while (bit_q.size() > 0) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                bit_valid = 1'b0;
                cycle();
            end
            bit_in    = bit_q.pop_front();
            bit_valid = 1'b1;
            waited    = 0;
            while (!bit_ready && waited < 200) begin
                cycle();
                waited++;
            end
            check("bit_ready within budget", bit_ready, 1);
            if (!bit_ready) begin
                bit_q.delete();
            end else begin
                cycle();
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            cycle();
            w++;
        end
        check("pending expected symbols", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) cycle();
        check("symbol_valid idle after drain", symbol_valid, 0);
    endtask

    task automatic set_mississippi();
        for (int k = 0; k < 16; k++) tbl[k] = 0;
        tbl[0] = 3;
        tbl[1] = 2;
        tbl[2] = 1;
        tbl[3] = 3;
    endtask

    task automatic run_mississippi(input int mode);
        int syms[11] = '{0, 1, 2, 2, 1, 2, 2, 1, 3, 3, 1};
        set_mississippi();
        load_table(mode);
        wait_ready();
        foreach (syms[i]) exp_q.push_back(syms[i]);
        queue_bits("110100010001011111110");
        send_bits(mode);
        drain();
    endtask

    // Feeds 15 bits that can never match; error must rise on exactly the 15th.
    task automatic run_error_case(input bit lead_one, input string tag);
        int waited;
        load_table(0);
        wait_ready();
        for (int i = 0; i < 15; i++) begin
            bit_in    = (i == 0 && lead_one) ? 1'b1 : 1'($urandom_range(0, 1));
            bit_valid = 1'b1;
            waited    = 0;
            while (!bit_ready && waited < 50) begin
                cycle();
                waited++;
            end
            check({tag, " bit_ready before code end"}, bit_ready, 1);
            cycle();
            if (i == 13) check({tag, " error after 14 bits"}, error, 0);
        end
        check({tag, " error after 15 bits"}, error, 1);
        check({tag, " bit_ready after error"}, bit_ready, 0);
        check({tag, " symbol_valid after error"}, symbol_valid, 0);
        repeat (4) cycle();
        check({tag, " error sticky"}, error, 1);
        check({tag, " no symbol while errored"}, symbol_valid, 0);
        bit_valid = 1'b0;
    endtask

    initial begin
        int c;
        int used[$];
        reset = 1'b1;
        table_clear = 1'b0;
        len_valid = 1'b0;
        len_in = '0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        check_defaults("after reset");

        // Reset in the middle of BUILD, then time a full back-to-back load.
        set_mississippi();
        load_table(0);
        check("len_ready in BUILD", len_ready, 0);
        check("bit_ready in BUILD", bit_ready, 0);
        repeat (100) cycle();
        check("table_ready mid-BUILD", table_ready, 0);
        reset = 1'b1;
        #1;
        check_defaults("reset mid-BUILD");
        cycle();
        reset = 1'b0;
        load_table(0);
        c = 0;
        while (!table_ready && c < 400) begin
            cycle();
            c++;
        end
        check("load-to-ready cycles", c + 16, 256);

        run_mississippi(0);

        // Backpressure: the held symbol must not let the next code's bits in.
        ready_hold = 1'b1;
        cycle();
        exp_q.push_back(2);
        queue_bits("0");
        send_bits(0);
        check("bp symbol_valid after 1-bit code", symbol_valid, 1);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp symbol_out held", symbol_out, 2);
            check("bp bit_ready while held", bit_ready, 0);
        end
        bit_valid  = 1'b0;
        ready_hold = 1'b0;
        exp_q.push_back(1);
        queue_bits("10");
        send_bits(0);
        drain();

        // Invalid code: only symbol 5 with code 00, stream starts with 1.
        for (int k = 0; k < 16; k++) tbl[k] = 0;
        tbl[5] = 2;
        run_error_case(1'b1, "lone sym5");
        for (int k = 0; k < 16; k++) tbl[k] = 0;
        run_error_case(1'b0, "empty table");

        // Reload: clear while a symbol is pending, then a flat 4-bit table.
        set_mississippi();
        load_table(0);
        wait_ready();
        ready_hold = 1'b1;
        cycle();
        queue_bits("0");
        send_bits(0);
        check("reload symbol pending before clear", symbol_valid, 1);
        table_clear = 1'b1;
        cycle();
        table_clear = 1'b0;
        check("reload symbol_valid after clear", symbol_valid, 0);
        check("reload len_ready after clear", len_ready, 1);
        check("reload table_ready after clear", table_ready, 0);
        ready_hold = 1'b0;
        for (int k = 0; k < 16; k++) tbl[k] = 4;
        load_table(0);
        wait_ready();
        exp_q.push_back(11);
        queue_bits("1011");
        send_bits(0);
        drain();

        run_mississippi(1);

        // Random tables, random symbol streams, random gaps on every handshake.
        for (int t = 0; t < 6; t++) begin
            rand_table();
            build_model();
            load_table(2);
            wait_ready();
            used.delete();
            for (int k = 0; k < 16; k++) if (tbl[k] != 0) used.push_back(k);
            for (int n = 0; n < 25; n++) push_symbol(used[$urandom_range(0, used.size() - 1)]);
            ready_random = 1'b1;
            send_bits(2);
            drain();
            ready_random = 1'b0;
            check("random table no error", error, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
